mux_scan_nx1: RTL and testbench
===============================

Name: mux_scan_nx1

Overview:
Parametrised N-to-1 multiplexer, successor to the fixed 8:1 combinational mux, with a registered output and two modes.
- Manual mode: the channel is chosen by an external select.
- Auto-scan mode: an internal pointer walks all channels round-robin with a programmable dwell time.
- Used as a time-division serialiser feeding narrow debug/observe paths and shared downstream logic.

Parameters:
N_CH, 8, number of input channels (2..256)
DATA_W, 1, width of each channel in bits
DWELL, 1, cycles each channel is held in auto-scan mode (1..65535)
SEL_W, $clog2(N_CH), select width; derived localparam, not overridable

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
en  in  1  global enable; 0 freezes all state
mode  in  1  0 = manual, 1 = auto-scan
sel_in  in  SEL_W  manual channel select
I  in  N_CH*DATA_W  packed inputs; channel k = I[k*DATA_W +: DATA_W]
out  out  DATA_W  registered selected data
sel_out  out  SEL_W  channel index that produced the current out
out_valid  out  1  out holds valid data this cycle
frame_start  out  1  one-cycle pulse on the first cycle of channel 0 in auto-scan
sel_err  out  1  manual select out of range (sel_in >= N_CH)

Behaviour:
- Reset: on rst=1 at a clock edge, all outputs go to 0; the scan pointer and dwell counter go to 0. rst overrides en and mode, including mid-scan.
- Latency: one cycle. Inputs sampled at edge t appear on out, sel_out and flags after edge t.
- en=0: out, sel_out, pointer and dwell counter hold their values; out_valid, frame_start and sel_err go to 0.
- Manual (mode=0, en=1):
  - out <= channel sel_in; sel_out <= sel_in; out_valid <= 1.
  - If sel_in >= N_CH: out <= 0, out_valid <= 0, sel_err <= 1.
- Auto-scan (mode=1, en=1):
  - out <= channel[ptr]; sel_out <= ptr; out_valid <= 1.
  - Dwell counter counts 0..DWELL-1. At DWELL-1 it clears and ptr advances.
  - ptr wraps N_CH-1 -> 0. This is correct for non-power-of-two N_CH; ptr never exceeds N_CH-1.
  - frame_start <= 1 when ptr=0 and dwell counter=0.
  - sel_in is ignored and sel_err=0.
- Mode change:
  - manual -> auto: ptr and dwell counter restart at 0, so the first auto cycle asserts frame_start.
  - auto -> manual: takes effect on the next edge; the scan state is discarded.
- I changing mid-dwell: the new value is sampled on the next edge. The output is not latched per dwell.
- DWELL=1: pointer advances every enabled cycle.
- Counter widths: dwell counter is $clog2(DWELL+1) bits, minimum 1.

Optional Feature:
MUX_PARITY_EN
- Defined: adds output port out_par (1 bit), the registered even parity (XOR-reduce) of the value loaded into out. It updates on the same edge as out, is 0 on reset, and holds when en=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg holds:
  - MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1;
  - the DWELL maximum constant;
  - a clog2-with-minimum-1 helper function.
- One sub-module, mux_scan_ctrl, owns the dwell counter and scan pointer and outputs ptr and first_of_frame.
- The top level does the channel slice, range check and output registers.

Test Plan:
- Manual, N_CH=8, DATA_W=1, I=8'b10101010, sel_in 0..7 one per cycle -> out 0,1,0,1,0,1,0,1 one cycle later; sel_err=0; out_valid=1.
- Auto, DWELL=1, same I -> out alternates 0/1; sel_out 0..7 then wraps to 0; frame_start pulses every 8 cycles.
- Auto, DWELL=3, N_CH=4, DATA_W=4, I=16'hDCBA -> out = A,A,A,B,B,B,C,C,C,D,D,D,A...; frame_start once per 12 cycles.
- Auto scan, drop en for 5 cycles at ptr=5 -> out/sel_out held at ch5, out_valid=0; resumes with the remaining dwell.
- Manual, N_CH=6, sel_in=7 -> sel_err=1, out_valid=0, out=0; then sel_in=2 -> out=I[2], flags clear.
- rst=1 asserted mid-scan at ptr=3 -> all outputs 0 next cycle; on release, auto restarts at ch0 with frame_start=1. With MUX_PARITY_EN, out_par=^out on every cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the scanning N:1 multiplexer (mux_scan_nx1).
//   - mode_e      : operating mode encoding (manual select / auto-scan)
//   - DWELL_MAX   : largest dwell time the scan controller supports
//   - clog2_min1  : ceil(log2(x)) clamped to at least 1, used to size
//                   counters that must never collapse to zero bits
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int unsigned DWELL_MAX = 32'd65535;

    // ceil(log2(value)), but never less than one bit
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = $clog2(value);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Round-robin scan pointer with programmable dwell for mux_scan_nx1.
// The pointer stays on each channel for DWELL enabled cycles, then moves to
// the next channel, wrapping N_CH-1 -> 0 (valid for any N_CH, not only
// powers of two). Outside scan mode the state is parked at zero so that the
// first scan cycle after a mode change always starts a fresh frame.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active-high
//   en             in   enable; 0 freezes pointer and dwell counter
//   scan           in   1 = auto-scan mode active, 0 = manual (state parked)
//   ptr            out  current scan channel (SEL_W bits)
//   first_of_frame out  1 while ptr = 0 and the dwell counter = 0
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter  int unsigned N_CH  = 8,
    parameter  int unsigned DWELL = 1,
    localparam int unsigned SEL_W = $clog2(N_CH),
    localparam int unsigned CNT_W = clog2_min1(DWELL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             scan,
    output logic [SEL_W-1:0] ptr,
    output logic             first_of_frame
);

    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptr_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next-state for the dwell counter and scan pointer
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        if (!en) begin
            ptr_nxt_s = ptr_r;
            cnt_nxt_s = cnt_r;
        end else if (scan) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s = {CNT_W{1'b0}};
                // explicit wrap so a non-power-of-two N_CH never overshoots
                if (ptr_r == PTR_LAST) begin
                    ptr_nxt_s = {SEL_W{1'b0}};
                end else begin
                    ptr_nxt_s = ptr_r + SEL_W'(1);
                end
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                ptr_nxt_s = ptr_r;
            end
        end else begin
            // manual mode discards scan progress; next scan restarts at ch0
            ptr_nxt_s = {SEL_W{1'b0}};
            cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {SEL_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign ptr            = ptr_r;
    assign first_of_frame = (ptr_r == {SEL_W{1'b0}}) && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mux_scan_nx1.sv
// -----------------------------------------------------------------------------
// mux_scan_nx1
// Parametrised N:1 multiplexer with a registered output, used as a
// time-division serialiser. Manual mode picks the channel from sel_in;
// auto-scan mode walks every channel round-robin, holding each for DWELL
// cycles. One cycle of latency from inputs to all outputs.
//
// Optional build macro: MUX_PARITY_EN adds out_par, the even parity
// (XOR reduction) of the value loaded into out.
//
// Parameters: N_CH (2..256), DATA_W (>=1), DWELL (1..65535).
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high (overrides en/mode)
//   en           in   0 holds out/sel_out/scan state, clears the flags
//   mode         in   0 = manual, 1 = auto-scan
//   sel_in       in   manual channel select (SEL_W bits)
//   I            in   packed channels, channel k = I[k*DATA_W +: DATA_W]
//   out          out  registered selected data
//   sel_out      out  channel index that produced out
//   out_valid    out  out carries valid data this cycle
//   frame_start  out  pulse on the first cycle of channel 0 in auto-scan
//   sel_err      out  manual select out of range (sel_in >= N_CH)
//   out_par      out  (MUX_PARITY_EN only) even parity of out
// -----------------------------------------------------------------------------
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter  int unsigned N_CH   = 8,
    parameter  int unsigned DATA_W = 1,
    parameter  int unsigned DWELL  = 1,
    localparam int unsigned SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [N_CH*DATA_W-1:0]   I,
    output logic [DATA_W-1:0]        out,
    output logic [SEL_W-1:0]         sel_out,
    output logic                     out_valid,
    output logic                     frame_start,
    output logic                     sel_err
`ifdef MUX_PARITY_EN
    ,
    output logic                     out_par
`endif
);

    // AND-OR channel slice; an index with no matching channel yields zero
    function automatic logic [DATA_W-1:0] chan_pick(
        input logic [N_CH*DATA_W-1:0] bus,
        input logic [SEL_W-1:0]       idx
    );
        logic [DATA_W-1:0] res;
        logic              hit;
        res = {DATA_W{1'b0}};
        for (int k = 0; k < int'(N_CH); k++) begin
            hit = (idx == SEL_W'(k));
            res = res | (bus[k*DATA_W +: DATA_W] & {DATA_W{hit}});
        end
        return res;
    endfunction

`ifdef MUX_PARITY_EN
    // even parity of one data word
    function automatic logic even_par(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction
`endif

    logic                   scan_s;
    logic [SEL_W-1:0]       ptr_s;
    logic                   first_s;
    logic [SEL_W-1:0]       idx_s;
    logic [DATA_W-1:0]      pick_s;
    logic                   range_err_s;

    logic [DATA_W-1:0]      out_nxt_s;
    logic [SEL_W-1:0]       sel_out_nxt_s;
    logic                   valid_nxt_s;
    logic                   fs_nxt_s;
    logic                   err_nxt_s;

    logic [DATA_W-1:0]      out_r;
    logic [SEL_W-1:0]       sel_out_r;
    logic                   valid_r;
    logic                   fs_r;
    logic                   err_r;

    assign scan_s = (mode == MODE_SCAN);

    mux_scan_ctrl #(
        .N_CH  (N_CH),
        .DWELL (DWELL)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .scan           (scan_s),
        .ptr            (ptr_s),
        .first_of_frame (first_s)
    );

    // Range check: extend by one bit so N_CH = 2**SEL_W is representable
    assign range_err_s = ({1'b0, sel_in} >= (SEL_W + 1)'(N_CH));

    assign idx_s  = scan_s ? ptr_s : sel_in;
    assign pick_s = chan_pick(I, idx_s);

    // Next values for the output registers
    always_comb begin
        out_nxt_s     = out_r;
        sel_out_nxt_s = sel_out_r;
        valid_nxt_s   = 1'b0;
        fs_nxt_s      = 1'b0;
        err_nxt_s     = 1'b0;
        if (!en) begin
            // data and index hold, all flags drop
            out_nxt_s     = out_r;
            sel_out_nxt_s = sel_out_r;
        end else if (scan_s) begin
            out_nxt_s     = pick_s;
            sel_out_nxt_s = ptr_s;
            valid_nxt_s   = 1'b1;
            fs_nxt_s      = first_s;
        end else if (range_err_s) begin
            out_nxt_s     = {DATA_W{1'b0}};
            sel_out_nxt_s = sel_in;
            err_nxt_s     = 1'b1;
        end else begin
            out_nxt_s     = pick_s;
            sel_out_nxt_s = sel_in;
            valid_nxt_s   = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= {DATA_W{1'b0}};
            sel_out_r <= {SEL_W{1'b0}};
            valid_r   <= 1'b0;
            fs_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            out_r     <= out_nxt_s;
            sel_out_r <= sel_out_nxt_s;
            valid_r   <= valid_nxt_s;
            fs_r      <= fs_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

`ifdef MUX_PARITY_EN
    logic par_r;

    // Parity register; follows out_nxt_s so it also holds while en=0
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else begin
            par_r <= even_par(out_nxt_s);
        end
    end

    assign out_par = par_r;
`endif

    assign out         = out_r;
    assign sel_out     = sel_out_r;
    assign out_valid   = valid_r;
    assign frame_start = fs_r;
    assign sel_err     = err_r;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_nx1
// Directed bench for mux_scan_nx1 with three configurations:
//   A: N_CH=8, DATA_W=1, DWELL=1  (manual sweep, auto wrap, mid-scan reset)
//   B: N_CH=4, DATA_W=4, DWELL=3  (dwell timing, I changing mid-dwell)
//   C: N_CH=6, DATA_W=4, DWELL=2  (range errors, en freeze, mode changes)
// Inputs change after the falling edge; outputs are sampled on the falling
// edge following the rising edge that registered them.
// -----------------------------------------------------------------------------
module tb_mux_scan_nx1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- instance A ----------------
    logic       rst_a, en_a, mode_a;
    logic [2:0] sel_a;
    logic [7:0] i_a;
    logic       out_a;
    logic [2:0] so_a;
    logic       ov_a, fs_a, se_a;
`ifdef MUX_PARITY_EN
    logic       par_a;
`endif

    mux_scan_nx1 #(.N_CH(8), .DATA_W(1), .DWELL(1)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel_in(sel_a), .I(i_a),
        .out(out_a), .sel_out(so_a), .out_valid(ov_a), .frame_start(fs_a), .sel_err(se_a)
`ifdef MUX_PARITY_EN
        , .out_par(par_a)
`endif
    );

    // ---------------- instance B ----------------
    logic        rst_b, en_b, mode_b;
    logic [1:0]  sel_b;
    logic [15:0] i_b;
    logic [3:0]  out_b;
    logic [1:0]  so_b;
    logic        ov_b, fs_b, se_b;
`ifdef MUX_PARITY_EN
    logic        par_b;
`endif

    mux_scan_nx1 #(.N_CH(4), .DATA_W(4), .DWELL(3)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel_in(sel_b), .I(i_b),
        .out(out_b), .sel_out(so_b), .out_valid(ov_b), .frame_start(fs_b), .sel_err(se_b)
`ifdef MUX_PARITY_EN
        , .out_par(par_b)
`endif
    );

    // ---------------- instance C ----------------
    logic        rst_c, en_c, mode_c;
    logic [2:0]  sel_c;
    logic [23:0] i_c;
    logic [3:0]  out_c;
    logic [2:0]  so_c;
    logic        ov_c, fs_c, se_c;
`ifdef MUX_PARITY_EN
    logic        par_c;
`endif

    mux_scan_nx1 #(.N_CH(6), .DATA_W(4), .DWELL(2)) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .mode(mode_c), .sel_in(sel_c), .I(i_c),
        .out(out_c), .sel_out(so_c), .out_valid(ov_c), .frame_start(fs_c), .sel_err(se_c)
`ifdef MUX_PARITY_EN
        , .out_par(par_c)
`endif
    );

    // hand-computed expectations
    logic       exp_bit_a [8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_out_b [12] = '{4'hA, 4'hA, 4'hA, 4'hB, 4'hB, 4'hB,
                                   4'hC, 4'hC, 4'hC, 4'hD, 4'hD, 4'hD};
    logic [1:0] exp_so_b  [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                   2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       exp_par_b [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [3:0] eb;
        logic       ep;

        rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; sel_a = 3'd0; i_a = 8'b1010_1010;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; sel_b = 2'd0; i_b = 16'hDCBA;
        rst_c = 1'b1; en_c = 1'b0; mode_c = 1'b0; sel_c = 3'd0; i_c = 24'h654321;
        tick();

        // reset state
        check_eq("a_rst_out",   32'(out_a), 32'd0);
        check_eq("a_rst_sel",   32'(so_a),  32'd0);
        check_eq("a_rst_valid", 32'(ov_a),  32'd0);
        check_eq("a_rst_fs",    32'(fs_a),  32'd0);
        check_eq("a_rst_err",   32'(se_a),  32'd0);
        check_eq("c_rst_out",   32'(out_c), 32'd0);

        // ---- A: manual sweep over all channels ----
        rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel_a = 3'(s);
            tick();
            check_eq("a_man_out",   32'(out_a), 32'(exp_bit_a[s]));
            check_eq("a_man_sel",   32'(so_a),  32'(s));
            check_eq("a_man_valid", 32'(ov_a),  32'd1);
            check_eq("a_man_err",   32'(se_a),  32'd0);
            check_eq("a_man_fs",    32'(fs_a),  32'd0);
        end

        // ---- A: auto-scan, DWELL=1, run into ptr=3 of the third frame ----
        mode_a = 1'b1;
        for (int c = 0; c < 19; c++) begin
            tick();
            check_eq("a_scan_sel",   32'(so_a),  32'(c % 8));
            check_eq("a_scan_out",   32'(out_a), 32'(exp_bit_a[c % 8]));
            check_eq("a_scan_fs",    32'(fs_a),  32'((c % 8) == 0));
            check_eq("a_scan_valid", 32'(ov_a),  32'd1);
`ifdef MUX_PARITY_EN
            check_eq("a_scan_par",   32'(par_a), 32'(exp_bit_a[c % 8]));
`endif
        end

        // reset mid-scan overrides en and mode
        rst_a = 1'b1;
        tick();
        check_eq("a_mrst_sel",   32'(so_a),  32'd0);
        check_eq("a_mrst_valid", 32'(ov_a),  32'd0);
        check_eq("a_mrst_fs",    32'(fs_a),  32'd0);
        check_eq("a_mrst_out",   32'(out_a), 32'd0);
        rst_a = 1'b0;
        tick();
        check_eq("a_rel_sel",   32'(so_a),  32'd0);
        check_eq("a_rel_fs",    32'(fs_a),  32'd1);
        check_eq("a_rel_valid", 32'(ov_a),  32'd1);
        tick();
        check_eq("a_rel2_sel",  32'(so_a),  32'd1);
        check_eq("a_rel2_out",  32'(out_a), 32'd1);
        check_eq("a_rel2_fs",   32'(fs_a),  32'd0);

        // ---- B: auto-scan, DWELL=3, two frames, I change mid-dwell ----
        rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c == 13) i_b = 16'hDCB5;
            if (c == 15) i_b = 16'hDCBA;
            eb = exp_out_b[c % 12];
            ep = exp_par_b[c % 12];
            if (c == 13 || c == 14) begin
                eb = 4'h5;
                ep = 1'b0;
            end
            tick();
            check_eq("b_scan_out", 32'(out_b), 32'(eb));
            check_eq("b_scan_sel", 32'(so_b),  32'(exp_so_b[c % 12]));
            check_eq("b_scan_fs",  32'(fs_b),  32'((c % 12) == 0));
            check_eq("b_scan_err", 32'(se_b),  32'd0);
`ifdef MUX_PARITY_EN
            check_eq("b_scan_par", 32'(par_b), 32'(ep));
`endif
        end

        // ---- C: manual with out-of-range selects (N_CH=6) ----
        rst_c = 1'b0; en_c = 1'b1; mode_c = 1'b0;
        sel_c = 3'd3; tick();
        check_eq("c_man3_out",   32'(out_c), 32'h4);
        check_eq("c_man3_valid", 32'(ov_c),  32'd1);
        sel_c = 3'd7; tick();
        check_eq("c_err7_out",   32'(out_c), 32'h0);
        check_eq("c_err7_valid", 32'(ov_c),  32'd0);
        check_eq("c_err7_err",   32'(se_c),  32'd1);
        sel_c = 3'd6; tick();
        check_eq("c_err6_err",   32'(se_c),  32'd1);
        check_eq("c_err6_valid", 32'(ov_c),  32'd0);
        sel_c = 3'd5; tick();
        check_eq("c_man5_out",   32'(out_c), 32'h6);
        check_eq("c_man5_err",   32'(se_c),  32'd0);
        sel_c = 3'd2; tick();
        check_eq("c_man2_out",   32'(out_c), 32'h3);
        check_eq("c_man2_sel",   32'(so_c),  32'd2);
        check_eq("c_man2_valid", 32'(ov_c),  32'd1);
        check_eq("c_man2_err",   32'(se_c),  32'd0);
        en_c = 1'b0; tick();
        check_eq("c_hold_out",   32'(out_c), 32'h3);
        check_eq("c_hold_valid", 32'(ov_c),  32'd0);

        // ---- C: auto-scan, DWELL=2, freeze at ch5 mid-dwell ----
        en_c = 1'b1; mode_c = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            check_eq("c_scan_sel", 32'(so_c),  32'(c / 2));
            check_eq("c_scan_out", 32'(out_c), 32'(c / 2 + 1));
            check_eq("c_scan_fs",  32'(fs_c),  32'(c == 0));
        end
        en_c = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("c_frz_out",   32'(out_c), 32'h6);
            check_eq("c_frz_sel",   32'(so_c),  32'd5);
            check_eq("c_frz_valid", 32'(ov_c),  32'd0);
            check_eq("c_frz_fs",    32'(fs_c),  32'd0);
        end
        en_c = 1'b1;
        tick();
        check_eq("c_res_sel",   32'(so_c),  32'd5);
        check_eq("c_res_out",   32'(out_c), 32'h6);
        check_eq("c_res_valid", 32'(ov_c),  32'd1);
        tick();
        check_eq("c_wrap_sel", 32'(so_c),  32'd0);
        check_eq("c_wrap_out", 32'(out_c), 32'h1);
        check_eq("c_wrap_fs",  32'(fs_c),  32'd1);
        tick();
        check_eq("c_wrap2_sel", 32'(so_c), 32'd0);
        check_eq("c_wrap2_fs",  32'(fs_c), 32'd0);

        // auto -> manual -> auto restarts the frame
        mode_c = 1'b0; sel_c = 3'd1; tick();
        check_eq("c_a2m_out", 32'(out_c), 32'h2);
        check_eq("c_a2m_sel", 32'(so_c),  32'd1);
        check_eq("c_a2m_fs",  32'(fs_c),  32'd0);
        mode_c = 1'b1; tick();
        check_eq("c_m2a_sel", 32'(so_c),  32'd0);
        check_eq("c_m2a_out", 32'(out_c), 32'h1);
        check_eq("c_m2a_fs",  32'(fs_c),  32'd1);
`ifdef MUX_PARITY_EN
        check_eq("c_m2a_par", 32'(par_c), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
